// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared types and defaults for the scoreboarded register file
//
// Purpose : state encoding of the clear-sweep FSM and default geometry.
// Contents: rf_state_t (RF_CLEAR, RF_READY), XLEN_DEFAULT, NREGS_DEFAULT.
package regfile_sb_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

endpackage

// File: rtl/regfile_sb_clear.sv
// rtl/regfile_sb_clear.sv - post-reset clear sweep FSM for regfile_sb
//
// Purpose : after reset, walk a counter over every register so that storage
//           can be zeroed without putting an async reset on the array.
// Ports   : clk, rst        - clock, async active-high reset
//           ready_o         - high once the sweep has written the last register
//           clr_en_o        - storage write enable for the sweep
//           clr_addr_o      - register being cleared this cycle
module regfile_sb_clear
  import regfile_sb_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready_o,
  output logic          clr_en_o,
  output logic [AW-1:0] clr_addr_o
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      // The edge that clears the last register is also the edge that
      // raises ready; the counter is parked at 0 afterwards.
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = RF_READY;
        cnt_d   = '0;
      end
    end
  end

  assign ready_o    = (state_q == RF_READY);
  assign clr_en_o   = (state_q == RF_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2-read/1-write register file with clear sweep and busy scoreboard
//
// Purpose : architectural register file for the tinyrv1 datapath with a
//           per-register busy bit used by decode to stall on pending writes.
// Ports   : clk, rst                - clock, async active-high reset
//           ready                   - storage sweep complete
//           wen, waddr, wdata       - write port (also clears busy[waddr])
//           raddr0/1, rdata0/1      - combinational read ports
//           rsv_en, rsv_addr        - reserve port (sets busy[rsv_addr])
//           busy0/1                 - busy bit of raddr0/1
// Options : REGFILE_SB_BYPASS_EN - forward same-cycle write data to the read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NREGS    = NREGS_DEFAULT,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr0,
  output logic [XLEN-1:0] rdata0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            busy0,
  output logic            busy1
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             clr_en;
  logic [AW-1:0]    clr_addr;

  logic [AW-1:0]    raddr_a [2];
  logic [XLEN-1:0]  rdata_a [2];
  logic             busy_a  [2];

  // Addresses past NREGS (non power-of-2 depth) and the hard-wired zero
  // register are treated as nonexistent.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_sb_clear #(.NREGS(NREGS)) u_clear (
    .clk       (clk),
    .rst       (rst),
    .ready_o   (ready),
    .clr_en_o  (clr_en),
    .clr_addr_o(clr_addr)
  );

  // Storage is deliberately not reset; the sweep owns the write port until ready.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      regs_q[clr_addr] <= '0;
    end else if (wen && addr_valid(waddr)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Reserve is applied after the write clear so a same-address pair ends busy.
  always_comb begin
    busy_d = busy_q;
    if (ready) begin
      if (wen && addr_valid(waddr)) busy_d[waddr] = 1'b0;
      if (rsv_en && addr_valid(rsv_addr)) busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign raddr_a[0] = raddr0;
  assign raddr_a[1] = raddr1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_a[p] = '0;
      busy_a[p]  = 1'b0;
      if (ready && addr_valid(raddr_a[p])) begin
        rdata_a[p] = regs_q[raddr_a[p]];
        busy_a[p]  = busy_q[raddr_a[p]];
      end
`ifdef REGFILE_SB_BYPASS_EN
      if (ready && wen && addr_valid(waddr) && (waddr == raddr_a[p])) begin
        rdata_a[p] = wdata;
        busy_a[p]  = rsv_en && (rsv_addr == waddr);
      end
`endif
    end
  end

  assign rdata0 = rdata_a[0];
  assign rdata1 = rdata_a[1];
  assign busy0  = busy_a[0];
  assign busy1  = busy_a[1];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ready, wen, rsv_en, busy0, busy1;
  logic [4:0]  waddr, raddr0, raddr1, rsv_addr;
  logic [31:0] wdata, rdata0, rdata1;

  logic        ready2, wen2, rsv_en2, busy0_2, busy1_2;
  logic [4:0]  waddr2, raddr0_2, raddr1_2, rsv_addr2;
  logic [31:0] wdata2, rdata0_2, rdata1_2;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .ready(ready),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy0(busy0), .busy1(busy1)
  );

  regfile_sb #(.NREGS(20), .ZERO_REG(0)) dut2 (
    .clk(clk), .rst(rst), .ready(ready2),
    .wen(wen2), .waddr(waddr2), .wdata(wdata2),
    .raddr0(raddr0_2), .rdata0(rdata0_2), .raddr1(raddr1_2), .rdata1(rdata1_2),
    .rsv_en(rsv_en2), .rsv_addr(rsv_addr2), .busy0(busy0_2), .busy1(busy1_2)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  chk_addr;
    logic [31:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic m_valid(input int a, input int n, input int z);
    return (a < n) && !(z != 0 && a == 0);
  endfunction

  task automatic idle_inputs();
    wen = 0; waddr = 0; wdata = 0; rsv_en = 0; rsv_addr = 0; raddr0 = 0; raddr1 = 0;
    wen2 = 0; waddr2 = 0; wdata2 = 0; rsv_en2 = 0; rsv_addr2 = 0; raddr0_2 = 0; raddr1_2 = 0;
  endtask

  // Release reset and track the sweep: ready must rise exactly NREGS edges later.
  task automatic release_and_sweep();
    @(negedge clk);
    rst = 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ready32_cyc%0d", k), 32'(ready), 32'(k >= 32));
      chk($sformatf("ready20_cyc%0d", k), 32'(ready2), 32'(k >= 20));
    end
    for (int a = 0; a < 32; a += 2) begin
      raddr0 = 5'(a);
      raddr1 = 5'(a + 1);
      #1;
      chk($sformatf("sweep_rd0_r%0d", a), rdata0, 32'h0);
      chk($sformatf("sweep_rd1_r%0d", a + 1), rdata1, 32'h0);
    end
    for (int a = 0; a < 32; a++) begin
      m_mem[a]  = '0;
      m_busy[a] = 1'b0;
    end
  endtask

  task automatic op(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                    input logic r, input logic [4:0] ra);
    @(negedge clk);
    wen = w; waddr = wa; wdata = wd; rsv_en = r; rsv_addr = ra;
    @(posedge clk);
    #1;
    wen = 0; rsv_en = 0;
  endtask

  initial begin
    logic [31:0] exp_d;
    logic        exp_b;
    int          ra;

    idle_inputs();
    vecs[0] = '{1'b1, 5'd6,  32'h0BADF00D, 1'b0, 5'd0,  5'd6,  32'h0BADF00D, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  32'h0,        1'b1};
    vecs[2] = '{1'b1, 5'd7,  32'h55,       1'b0, 5'd0,  5'd7,  32'h55,       1'b0};
    vecs[3] = '{1'b1, 5'd9,  32'hAA,       1'b1, 5'd9,  5'd9,  32'hAA,       1'b1};
    vecs[4] = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  5'd0,  32'h0,        1'b0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd31, 32'h0,        1'b1};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd31, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  32'hDEADBEEF, 1'b0};

    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_busy0", 32'(busy0), 32'h0);
    release_and_sweep();

    // Same-cycle read of a register being written.
    @(negedge clk);
    wen = 1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr0 = 5'd5;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk("wr_same_cycle", rdata0, 32'hDEADBEEF);
`else
    chk("wr_same_cycle", rdata0, 32'h0);
`endif
    @(posedge clk);
    #1;
    wen = 0;
    #1;
    chk("wr_next_cycle", rdata0, 32'hDEADBEEF);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
      raddr0 = vecs[i].chk_addr; raddr1 = vecs[i].chk_addr;
      @(posedge clk);
      #1;
      wen = 0; rsv_en = 0;
      #1;
      chk($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].exp_data);
      chk($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp_data);
      chk($sformatf("vec%0d_busy0", i), 32'(busy0), 32'(vecs[i].exp_busy));
    end

    // Mid-operation reset: busy and ready drop without waiting for a clock.
    op(1, 5'd1, 32'h11, 0, 5'd0);
    op(1, 5'd2, 32'h22, 0, 5'd0);
    op(1, 5'd3, 32'h33, 1, 5'd2);
    raddr0 = 5'd2;
    raddr1 = 5'd3;
    #1;
    chk("midrst_pre_busy", 32'(busy0), 32'h1);
    chk("midrst_pre_data", rdata1, 32'h33);
    #1;
    rst = 1;
    #1;
    chk("midrst_busy", 32'(busy0), 32'h0);
    chk("midrst_ready", 32'(ready), 32'h0);
    @(posedge clk);
    release_and_sweep();

    // Random traffic against the array model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wen = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      rsv_en = ($urandom_range(0, 3) == 0);
      rsv_addr = 5'($urandom_range(0, 31));
      raddr0 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr1 = 5'($urandom_range(0, 31));
      #1;
      for (int p = 0; p < 2; p++) begin
        ra = (p == 0) ? int'(raddr0) : int'(raddr1);
        exp_d = m_valid(ra, 32, 1) ? m_mem[ra] : 32'h0;
        exp_b = m_valid(ra, 32, 1) ? m_busy[ra] : 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (wen && m_valid(int'(waddr), 32, 1) && ra == int'(waddr)) begin
          exp_d = wdata;
          exp_b = rsv_en && (rsv_addr == waddr);
        end
`endif
        chk($sformatf("rand%0d_rdata%0d", i, p), (p == 0) ? rdata0 : rdata1, exp_d);
        chk($sformatf("rand%0d_busy%0d", i, p), 32'((p == 0) ? busy0 : busy1), 32'(exp_b));
      end
      @(posedge clk);
      if (wen && m_valid(int'(waddr), 32, 1)) begin
        m_mem[waddr]  = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (rsv_en && m_valid(int'(rsv_addr), 32, 1)) m_busy[rsv_addr] = 1'b1;
    end
    @(negedge clk);
    idle_inputs();

    // 20-entry instance without a zero register.
    @(negedge clk);
    wen2 = 1; waddr2 = 5'd0; wdata2 = 32'h7;
    @(posedge clk);
    #1;
    wen2 = 0;
    raddr0_2 = 5'd0;
    #1;
    chk("n20_r0", rdata0_2, 32'h7);
    @(negedge clk);
    wen2 = 1; waddr2 = 5'd19; wdata2 = 32'h13; rsv_en2 = 1; rsv_addr2 = 5'd19;
    @(posedge clk);
    #1;
    wen2 = 0; rsv_en2 = 0;
    raddr1_2 = 5'd19;
    #1;
    chk("n20_r19_data", rdata1_2, 32'h13);
    chk("n20_r19_busy", 32'(busy1_2), 32'h1);
    @(negedge clk);
    wen2 = 1; waddr2 = 5'd25; wdata2 = 32'h99; rsv_en2 = 1; rsv_addr2 = 5'd25;
    @(posedge clk);
    #1;
    wen2 = 0; rsv_en2 = 0;
    raddr0_2 = 5'd25;
    #1;
    chk("n20_r25_data", rdata0_2, 32'h0);
    chk("n20_r25_busy", 32'(busy0_2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 2-read/1-write architectural register file, used by the tinyrv1 datapath.
- Adds configurable width and depth, and a hard-wired-zero option.
- Adds a post-reset clear sweep with a `ready` flag, so storage is initialised without an async-reset array.
- Adds per-register busy (scoreboard) bits, which the decode stage uses to stall on pending writes from long-latency units.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; range 2..64; need not be a power of 2.
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes/reserves.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high once the clear sweep is complete.
- wen  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- raddr0  in  AW  read port 0 address.
- rdata0  out  XLEN  read port 0 data (combinational).
- raddr1  in  AW  read port 1 address.
- rdata1  out  XLEN  read port 1 data (combinational).
- rsv_en  in  1  reserve request: marks rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- busy0  out  1  busy bit of raddr0 (combinational).
- busy1  out  1  busy bit of raddr1 (combinational).

Behaviour:
- Reset (async assert): FSM enters CLEAR; sweep counter = 0; all busy bits = 0; ready = 0.
  - Storage array has no reset; it is zeroed by the sweep.
- CLEAR state:
  - Each posedge writes 0 to R[counter] and increments the counter.
  - The posedge that writes R[NREGS-1] moves the FSM to READY.
  - ready = 1 from that edge on, i.e. exactly NREGS cycles after rst deasserts.
  - wen and rsv_en are ignored.
  - rdata0/1 = 0 and busy0/1 = 0.
- READY state (terminal until the next rst):
  - Write: at posedge, if wen and address valid, R[waddr] <= wdata and busy[waddr] <= 0.
  - Reserve: at posedge, if rsv_en and address valid, busy[rsv_addr] <= 1.
  - Write and reserve to the same address in the same cycle: data is written, busy ends 1 (reserve wins; the new producer is outstanding).
  - Write to a register that is not busy is legal; busy stays 0.
- Valid address:
  - addr < NREGS, and
  - addr != 0 when ZERO_REG = 1.
  - Invalid writes/reserves are dropped.
  - Invalid reads return 0 with busy = 0.
- Reads:
  - rdataN = R[raddrN]; busyN = busy[raddrN].
  - No read-during-write forwarding unless the optional feature is enabled: a same-cycle write is visible the next cycle.
- Reset asserted mid-sweep or mid-operation: immediate return to CLEAR with counter 0; the sweep restarts from register 0.

Optional Feature:
- REGFILE_SB_BYPASS_EN defined:
  - In READY, if wen is high, waddr is valid and waddr == raddrN, then rdataN = wdata combinationally.
  - busyN = 0 for that port, unless rsv_en to the same address is also asserted, in which case busyN = 1.
- REGFILE_SB_BYPASS_EN undefined:
  - No bypass; reads reflect registered state only.

Decomposition:
- Package regfile_sb_pkg:
  - typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
  - localparam XLEN_DEFAULT = 32.
  - localparam NREGS_DEFAULT = 32.
- Sub-module regfile_sb_clear: sweep FSM, counter, ready output, and the clear-write address/enable mux.
- Top-level regfile_sb holds storage, busy vector, read muxes and bypass.

Test Plan:
- Reset/sweep: assert rst 3 cycles, release → ready = 0 for 32 cycles, ready = 1 on cycle 32; all 32 reads return 0.
- Write/read: after ready, write R5 = 0xDEADBEEF → same cycle rdata0 (raddr0 = 5) is old value (0); next cycle 0xDEADBEEF. With bypass macro, same cycle 0xDEADBEEF.
- Zero register: wen, waddr = 0, wdata = 0x1234 and rsv to 0 → rdata = 0 and busy = 0 thereafter.
- Scoreboard:
  - rsv R7 → busy0 = 1 next cycle.
  - Write R7 = 0x55 → busy0 = 0.
  - Simultaneous write R9 = 0xAA + rsv R9 → busy = 1, data 0xAA.
- Mid-op reset:
  - Fill R1..R3, reserve R2, assert rst mid-cycle → busy drops immediately, ready = 0.
  - After release, 32 cycles later all reads return 0.
- Non-power-of-2: NREGS = 20, ZERO_REG = 0 → write R0 = 7 reads back 7; write/read addr 25 → dropped, reads 0; ready after 20 cycles.
